uart_cmd_rx: RTL
================

# uart_cmd_rx

Serial receiver for the team's two-frame UART command format. It reassembles a 16-bit command from two back-to-back 11-bit frames, high byte first; each frame carries an odd-parity bit. It presents the command on a valid/ready output port and reports parity, framing, gap-timeout and overrun errors. It sits at the far end of the serial link from the command transmitter and feeds the downstream command decoder.

## Interface
- `BIT_CYCLES`, 16: clock cycles per serial bit; even, ≥4; same value as the transmitter.
- `GAP_BITS`, 4: maximum idle bit-times allowed between the high-byte stop bit and the low-byte start bit.
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous active-low reset.
- `rx` in 1: serial input, idle high, asynchronous to `clk`.
- `cmd_out` out 16: received command, `{high byte, low byte}`.
- `cmd_out_vld` out 1: `cmd_out` holds an untaken command.
- `cmd_out_rdy` in 1: consumer accepts; a transfer occurs on `cmd_out_vld && cmd_out_rdy`.
- `par_err` out 1: one-cycle pulse; a parity mismatch caused the command to be discarded.
- `frm_err` out 1: one-cycle pulse; a stop bit was sampled as 0, or the gap timed out.
- `ovr_err` out 1: one-cycle pulse; a completed command was dropped because the output was still full.
- `busy` out 1: high from a valid start-bit confirmation until the command is completed or discarded.

## Operation
- **Frame format**, on the wire in order: start (0), D7..D0 (MSB first), P, stop (1).
  - P = ~^D, so D plus P contains an odd number of ones.
  - Frame 1 carries `cmd[15:8]`; frame 2 carries `cmd[7:0]`.
- **Input synchronisation**
  - `rx` passes through a 2-flop synchroniser (reset value 1) to give `rx_s`, plus one history flop for edge detection.
  - A start is detected only on a 1→0 edge of `rx_s`.
- **FSM states:** IDLE, START, DATA, PARITY, STOP, GAP.
  - **IDLE**
    - On a falling edge: clear the bit counter and go to START.
    - A byte flag `hi` is set in IDLE.
  - **START**
    - At `BIT_CYCLES/2`, sample `rx_s`.
    - If 1 (glitch): go to IDLE with no error.
    - If 0: set `busy` and go to DATA.
  - **DATA**
    - Sample every `BIT_CYCLES` into an 8-bit MSB-first shift register.
    - After 8 samples, go to PARITY.
  - **PARITY**
    - Sample P and compute the parity mismatch.
    - Latch it into a sticky `perr` flag, which is cleared when a command starts.
    - Go to STOP.
  - **STOP**, one sample:
    - Stop = 0: pulse `frm_err`, discard the command, go to IDLE. The edge detector prevents re-triggering until `rx_s` has returned high.
    - Stop = 1 and `hi` set: store the high byte, clear `hi`, go to GAP.
    - Stop = 1 and `hi` clear: the command is complete.
      - If `perr` is set: pulse `par_err`, discard.
      - Otherwise deliver to the output register.
      - Then go to IDLE.
  - **GAP**
    - A falling edge goes to START.
    - A gap counter expiring at `GAP_BITS*BIT_CYCLES` cycles pulses `frm_err`, discards the high byte, and goes to IDLE.
- **Output register** (single entry)
  - Delivery while empty: load `cmd_out` and set `cmd_out_vld`.
  - Delivery in the same cycle as a transfer: load the new value; `cmd_out_vld` stays 1.
  - Delivery while full with no transfer: keep the old command and pulse `ovr_err`.
  - `cmd_out` holds its value after the transfer.
- **Error priority:** a framing error beats a parity error, which beats overrun. At most one error pulse per command.

## Timing
- **Reset values:** `cmd_out`=0, `cmd_out_vld`=0, `par_err`=`frm_err`=`ovr_err`=0, `busy`=0, FSM=IDLE, synchroniser=1.
- **Reset mid-frame:** all partial state is lost. After release, a fresh falling edge is needed, so a low `rx` held through reset is ignored.
- **Sample points:** let t0 be the cycle the falling edge is seen on `rx_s`.
  - Start is sampled at t0+`BIT_CYCLES/2`.
  - Bit k is sampled at t0+`BIT_CYCLES/2`+k·`BIT_CYCLES` (k=1..8 data, 9 parity, 10 stop).
- **Latency:** `rx` pin to `rx_s` is 2 cycles.
- **End of frame 2:** `cmd_out_vld` and the error pulses assert the cycle after the stop sample, and `busy` falls in that same cycle.
- **Gap start:** the GAP state is entered the cycle after the stop-bit sample of frame 1. A start edge during the second half of the stop bit is therefore accepted.
- **Counter widths:** the bit counter is `clog2(BIT_CYCLES)` bits; the gap counter is `clog2(GAP_BITS*BIT_CYCLES+1)` bits. Neither wraps; both are cleared on every state entry.

## Test plan
- **Basic command:** send 0xA55A (P=1 for both frames), `cmd_out_rdy`=1 → `cmd_out_vld` one-cycle pulse with `cmd_out`=0xA55A, exactly 2+`BIT_CYCLES/2`+10·`BIT_CYCLES`+1 cycles after the frame-2 start edge on `rx`; no errors.
- **Parity error:** send 0x0100 with the frame-2 P forced to 0 (correct is 1) → `par_err` pulse, `cmd_out_vld` stays 0; then 0x0100 with correct parity → delivered.
- **Framing errors:**
  - Frame-1 stop bit driven 0 → `frm_err` pulse, no delivery; the next valid command 0x1234 is received correctly.
  - Gap of `GAP_BITS`+1 bit-times idle after frame 1 → `frm_err` pulse, `busy` falls.
- **Back-pressure and overrun:** hold `cmd_out_rdy`=0, send 0x1111 then 0x2222 → `cmd_out`=0x1111 held, `ovr_err` pulse at 0x2222 completion; raise `cmd_out_rdy` exactly on that cycle instead → 0x2222 loaded, `cmd_out_vld` stays 1, no `ovr_err`.
- **Glitch rejection:** drive `rx` low for `BIT_CYCLES/2`−2 cycles → no `busy`, no errors; a following 0xFFFF (P=1, both frames) is received correctly.
- **Reset mid-frame:** assert `rst_n`=0 during DATA of frame 1 → all outputs at reset values; after release with `rx`=1, 0xBEEF is received correctly.

Source files
------------

// File: rtl/uart_cmd_rx.sv
// Two-frame UART command receiver: reassembles a 16-bit command from two odd-parity
// 11-bit frames (high byte first) and presents it on a single-entry valid/ready port.
module uart_cmd_rx #(
  parameter int BIT_CYCLES = 16,
  parameter int GAP_BITS   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx,
  output logic [15:0] cmd_out,
  output logic        cmd_out_vld,
  input  logic        cmd_out_rdy,
  output logic        par_err,
  output logic        frm_err,
  output logic        ovr_err,
  output logic        busy
);

  localparam int CNT_W = $clog2(BIT_CYCLES);
  localparam int GAP_W = $clog2(GAP_BITS * BIT_CYCLES + 1);

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BIT_CYCLES / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CYCLES - 1);
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(GAP_BITS * BIT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_GAP
  } state_t;

  // Synchroniser plus edge-detect history
  logic       rx_m, rx_s, rx_d;
  logic [1:0] warm;
  logic       fall;

  // History stays low until the synchroniser carries a real sample, so a line held
  // low through reset never looks like a falling edge.
  // NOTE: sequential state is always written with non-blocking (<=) so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      rx_d <= 1'b0;
      warm <= 2'b00;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
      warm <= {warm[0], 1'b1};
      rx_d <= warm[1] ? rx_s : 1'b0;
    end
  end

  assign fall = rx_d & ~rx_s;

  // Receiver FSM
  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [GAP_W-1:0] gcnt, gcnt_nxt;
  logic [2:0]       bit_idx, bit_idx_nxt;
  logic [7:0]       shift, shift_nxt;
  logic [7:0]       hi_byte, hi_byte_nxt;
  logic             hi, hi_nxt;
  logic             perr, perr_nxt;
  logic             busy_nxt;
  logic             par_p, frm_p, deliver;
  logic             bit_tick;

  assign bit_tick = (cnt == BIT_LAST);

  // NOTE: every signal driven here gets a default first, so no path can leave one
  // unassigned and infer a latch.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt + CNT_W'(1);
    gcnt_nxt    = '0;
    bit_idx_nxt = bit_idx;
    shift_nxt   = shift;
    hi_byte_nxt = hi_byte;
    hi_nxt      = hi;
    perr_nxt    = perr;
    busy_nxt    = busy;
    par_p       = 1'b0;
    frm_p       = 1'b0;
    deliver     = 1'b0;

    unique case (state)
      S_IDLE: begin
        cnt_nxt  = '0;
        hi_nxt   = 1'b1;
        busy_nxt = 1'b0;
        if (fall) state_nxt = S_START;
      end
      S_START: begin
        if (cnt == HALF_LAST) begin
          cnt_nxt = '0;
          if (rx_s) begin
            state_nxt = S_IDLE;
            busy_nxt  = 1'b0;
          end else begin
            state_nxt   = S_DATA;
            busy_nxt    = 1'b1;
            bit_idx_nxt = '0;
            if (hi) perr_nxt = 1'b0;
          end
        end
      end
      S_DATA: begin
        if (bit_tick) begin
          cnt_nxt     = '0;
          shift_nxt   = {shift[6:0], rx_s};
          bit_idx_nxt = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_nxt = S_PARITY;
        end
      end
      S_PARITY: begin
        if (bit_tick) begin
          cnt_nxt   = '0;
          // Correct P is ~^D, so a mismatch is P equal to the even-parity value
          perr_nxt  = perr | (rx_s == ^shift);
          state_nxt = S_STOP;
        end
      end
      S_STOP: begin
        if (bit_tick) begin
          cnt_nxt = '0;
          if (!rx_s) begin
            frm_p     = 1'b1;
            busy_nxt  = 1'b0;
            state_nxt = S_IDLE;
          end else if (hi) begin
            hi_byte_nxt = shift;
            hi_nxt      = 1'b0;
            state_nxt   = S_GAP;
          end else begin
            if (perr) par_p = 1'b1;
            else      deliver = 1'b1;
            busy_nxt  = 1'b0;
            state_nxt = S_IDLE;
          end
        end
      end
      S_GAP: begin
        cnt_nxt = '0;
        if (fall) begin
          state_nxt = S_START;
        end else if (gcnt == GAP_LAST) begin
          frm_p     = 1'b1;
          busy_nxt  = 1'b0;
          state_nxt = S_IDLE;
        end else begin
          gcnt_nxt = gcnt + GAP_W'(1);
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      gcnt    <= '0;
      bit_idx <= '0;
      shift   <= '0;
      hi_byte <= '0;
      hi      <= 1'b1;
      perr    <= 1'b0;
      busy    <= 1'b0;
      par_err <= 1'b0;
      frm_err <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      gcnt    <= gcnt_nxt;
      bit_idx <= bit_idx_nxt;
      shift   <= shift_nxt;
      hi_byte <= hi_byte_nxt;
      hi      <= hi_nxt;
      perr    <= perr_nxt;
      busy    <= busy_nxt;
      par_err <= par_p;
      frm_err <= frm_p;
    end
  end

  // Single-entry output register; a delivery may replace an entry leaving this cycle
  logic xfer;
  assign xfer = cmd_out_vld & cmd_out_rdy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_out     <= '0;
      cmd_out_vld <= 1'b0;
      ovr_err     <= 1'b0;
    end else begin
      ovr_err <= 1'b0;
      if (deliver) begin
        if (!cmd_out_vld || xfer) begin
          cmd_out     <= {hi_byte, shift};
          cmd_out_vld <= 1'b1;
        end else begin
          ovr_err <= 1'b1;
        end
      end else if (xfer) begin
        cmd_out_vld <= 1'b0;
      end
    end
  end

endmodule
